// File: rtl/logic_gate_pkg.sv
// ----------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the logic_gate_pipe block:
//   - 3-bit opcode constants OP_AND .. OP_BUF_A
//   - truth-table sweep FSM state encoding (ST_IDLE / ST_RUN / ST_DONE)
//   - gate_eval(): single-bit evaluation of one opcode; the datapath applies it
//     per bit, which is exact because every opcode is purely bitwise.
// ----------------------------------------------------------------------------
package logic_gate_pkg;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_NAND  = 3'd2;
   localparam logic [2:0] OP_NOR   = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_XNOR  = 3'd5;
   localparam logic [2:0] OP_NOT_A = 3'd6;
   localparam logic [2:0] OP_BUF_A = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_e;

   function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
      logic y;
      case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_NOT_A: y = ~a;
         OP_BUF_A: y = a;
         default:  y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/logic_gate_pipe_skid_buf.sv
// ----------------------------------------------------------------------------
// gate_skid_buf
// Two-entry valid/ready skid buffer. The "main" entry drives the output and
// doubles as the result capture register (data is visible the cycle after it
// is accepted). The "skid" entry catches one extra beat when the sink stalls.
// in_ready_o is a pure decode of the skid-occupied flop, so there is no
// combinational path from out_ready_i to in_ready_o.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid_i/in_ready_o   upstream handshake, in_data_i  DW-bit payload
//   out_valid_o/out_ready_i downstream handshake, out_data_o DW-bit payload
// ----------------------------------------------------------------------------
module gate_skid_buf #(
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o
);

   logic          main_v_q, main_v_d;
   logic [DW-1:0] main_data_q, main_data_d;
   logic          skid_v_q, skid_v_d;
   logic [DW-1:0] skid_data_q, skid_data_d;
   logic          push_s;
   logic          pop_s;

   // Next-state for both entries; the skid entry is only ever filled while main is held.
   always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      push_s      = in_valid_i & ~skid_v_q;
      pop_s       = main_v_q & out_ready_i;

      if (!main_v_q) begin
         if (push_s) begin
            main_v_d    = 1'b1;
            main_data_d = in_data_i;
         end else begin
            main_v_d    = 1'b0;
         end
      end else if (pop_s) begin
         if (skid_v_q) begin
            // Older skid beat moves up; push is blocked this cycle (in_ready low).
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
         end else if (push_s) begin
            // Drain and refill in the same cycle keeps full throughput.
            main_data_d = in_data_i;
         end else begin
            main_v_d    = 1'b0;
         end
      end else begin
         if (push_s) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data_i;
         end else begin
            skid_v_d    = skid_v_q;
         end
      end
   end

   // Entry registers; reset discards every held beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q    <= 1'b0;
         main_data_q <= '0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
      end else begin
         main_v_q    <= main_v_d;
         main_data_q <= main_data_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready_o  = ~skid_v_q;
   assign out_valid_o = main_v_q;
   assign out_data_o  = main_data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// ----------------------------------------------------------------------------
// logic_gate_pipe
// Opcode-selected WIDTH-bit bitwise gate unit (AND/OR/NAND/NOR/XOR/XNOR/NOT_A/
// BUF_A) with valid/ready on both sides, 1-cycle latency and full throughput.
// Results plus zero/all-ones flags are computed at capture and held in a
// two-entry skid buffer.
// Optional feature (macro TRUTH_SWEEP_EN): an internal FSM sweeps all
// 4^SWEEP_W operand combinations through the datapath using the opcode
// sampled at sweep_start.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               operand handshake (in_ready registered)
//   in_op[2:0], in_a, in_b          opcode and operands
//   out_valid/out_ready             result handshake
//   out_y, out_zero, out_ones       result and flags (held while stalled)
//   sweep_start/busy/done           sweep control (TRUTH_SWEEP_EN only)
// ----------------------------------------------------------------------------
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SWEEP_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_ones
`ifdef TRUTH_SWEEP_EN
   ,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done
`endif
);

   if (SWEEP_W < 1 || SWEEP_W > WIDTH) begin : g_bad_sweep_w
      $error("logic_gate_pipe: SWEEP_W must be in 1..WIDTH");
   end

   logic             dp_valid_s;
   logic [2:0]       dp_op_s;
   logic [WIDTH-1:0] dp_a_s;
   logic [WIDTH-1:0] dp_b_s;
   logic             buf_ready_s;
   logic [WIDTH-1:0] res_y_s;
   logic [WIDTH+1:0] buf_din_s;
   logic [WIDTH+1:0] buf_dout_s;

`ifdef TRUTH_SWEEP_EN
   localparam int CW = 2 * SWEEP_W;

   sweep_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    op_q, op_d;
   logic          run_s;

   // Sweep FSM next state: counter advances only on an accepted internal beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (sweep_start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               op_d    = in_op;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (buf_ready_s) begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == {CW{1'b1}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sweep FSM state, counter and latched opcode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign run_s = (state_q == ST_RUN);

   // Operand mux: sweep counter halves (zero-extended) replace the external beat during RUN.
   always_comb begin
      dp_a_s = '0;
      dp_b_s = '0;
      if (run_s) begin
         dp_valid_s             = 1'b1;
         dp_op_s                = op_q;
         dp_a_s[SWEEP_W-1:0]    = cnt_q[CW-1:SWEEP_W];
         dp_b_s[SWEEP_W-1:0]    = cnt_q[SWEEP_W-1:0];
      end else begin
         dp_valid_s             = in_valid;
         dp_op_s                = in_op;
         dp_a_s                 = in_a;
         dp_b_s                 = in_b;
      end
   end

   assign in_ready   = buf_ready_s & ~run_s;
   assign sweep_busy = run_s;
   assign sweep_done = (state_q == ST_DONE);
`else
   assign dp_valid_s = in_valid;
   assign dp_op_s    = in_op;
   assign dp_a_s     = in_a;
   assign dp_b_s     = in_b;
   assign in_ready   = buf_ready_s;
`endif

   // Bitwise gate evaluation of the selected operands.
   always_comb begin
      res_y_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         res_y_s[i] = gate_eval(dp_op_s, dp_a_s[i], dp_b_s[i]);
      end
   end

   // Flags are computed here so they travel with the result through the buffer.
   assign buf_din_s = {&res_y_s, ~|res_y_s, res_y_s};

   gate_skid_buf #(
      .DW (WIDTH + 2)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (dp_valid_s),
      .in_ready_o  (buf_ready_s),
      .in_data_i   (buf_din_s),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (buf_dout_s)
   );

   assign out_y    = buf_dout_s[WIDTH-1:0];
   assign out_zero = buf_dout_s[WIDTH];
   assign out_ones = buf_dout_s[WIDTH+1];

endmodule

// File: tb/tb_logic_gate_pipe.sv
module tb_logic_gate_pipe;

   localparam int W = 8;
`ifdef TRUTH_SWEEP_EN
   localparam int SW = 1;
`else
   localparam int SW = 2;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   in_op = 3'd0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_y;
   logic         out_zero;
   logic         out_ones;
`ifdef TRUTH_SWEEP_EN
   logic         sweep_start = 1'b0;
   logic         sweep_busy;
   logic         sweep_done;
`endif

   int n_checks = 0;
   int n_err    = 0;
   int n_out    = 0;
   bit sweep_mode = 1'b0;

   logic [W+1:0] exp_q[$];

   always #5 clk = ~clk;

   logic_gate_pipe #(.WIDTH(W), .SWEEP_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .out_ones  (out_ones)
`ifdef TRUTH_SWEEP_EN
      ,
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: {ones, zero, y} straight from the opcode table.
   function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] y;
      case (op)
         3'd0: y = a & b;
         3'd1: y = a | b;
         3'd2: y = ~(a & b);
         3'd3: y = ~(a | b);
         3'd4: y = a ^ b;
         3'd5: y = ~(a ^ b);
         3'd6: y = ~a;
         default: y = a;
      endcase
      return {(y == {W{1'b1}}), (y == '0), y};
   endfunction

   // Scoreboard: at each negedge handshakes reflect the coming posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else if (!sweep_mode) begin
         chk("valid_vs_model", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
         if (out_valid && out_ready && exp_q.size() > 0) begin
            logic [W+1:0] e;
            e = exp_q.pop_front();
            chk("out_y", {24'd0, out_y}, {24'd0, e[W-1:0]});
            chk("out_zero", {31'd0, out_zero}, {31'd0, e[W]});
            chk("out_ones", {31'd0, out_ones}, {31'd0, e[W+1]});
            n_out++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_op, in_a, in_b));
         end
      end
   end

   // Drive one beat and return #1 after the edge that accepted it.
   task automatic push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int guard;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         chk("push_timeout", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("drain_empty", exp_q.size(), 32'd0);
   endtask

   logic [W-1:0] lit_exp[8];
   logic [W-1:0] sw_y[$];
   int           done_cnt;

   initial begin
      lit_exp[0] = 8'hC0; lit_exp[1] = 8'hFC; lit_exp[2] = 8'h3F; lit_exp[3] = 8'h03;
      lit_exp[4] = 8'h3C; lit_exp[5] = 8'hC3; lit_exp[6] = 8'h0F; lit_exp[7] = 8'hF0;

      // Reset state
      #22 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_y", {24'd0, out_y}, 32'd0);
      chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
      chk("rst_out_ones", {31'd0, out_ones}, 32'd0);
`ifdef TRUTH_SWEEP_EN
      chk("rst_sweep_busy", {31'd0, sweep_busy}, 32'd0);
      chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
`endif

      // All opcodes on F0/CC, result one cycle after each accept
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(3'(i), 8'hF0, 8'hCC);
         chk("op_valid", {31'd0, out_valid}, 32'd1);
         chk("op_literal", {24'd0, out_y}, {24'd0, lit_exp[i]});
      end

      // Flag corners
      push(3'd2, 8'hFF, 8'hFF);
      chk("nand_ff_y", {24'd0, out_y}, 32'h00);
      chk("nand_ff_zero", {31'd0, out_zero}, 32'd1);
      push(3'd2, 8'h00, 8'h00);
      chk("nand_00_y", {24'd0, out_y}, 32'hFF);
      chk("nand_00_ones", {31'd0, out_ones}, 32'd1);
      drain();

      // Backpressure: two held, third stalls until release
      out_ready = 1'b0;
      push(3'd0, 8'hA5, 8'h0F);
      chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
      push(3'd4, 8'hA5, 8'hFF);
      chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; in_op = 3'd1; in_a = 8'h12; in_b = 8'h40;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_y", {24'd0, out_y}, 32'h05);
      end
      out_ready = 1'b1;
      n_out = 0;
      push(3'd1, 8'h12, 8'h40);
      drain();
      chk("bp_count", n_out, 32'd3);

      // Streaming: full throughput, in_ready never drops
      n_out = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_op = 3'($urandom_range(7, 0));
         in_a  = 8'($urandom);
         in_b  = 8'($urandom);
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
      chk("stream_count", n_out, 32'd100);

      // Reset mid-stream with two beats held
      out_ready = 1'b0;
      push(3'd7, 8'h5A, 8'h00);
      push(3'd6, 8'h5A, 8'h00);
      #2 rst_n = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_out_y", {24'd0, out_y}, 32'd0);
      chk("mid_rst_out_zero", {31'd0, out_zero}, 32'd0);
      chk("mid_rst_out_ones", {31'd0, out_ones}, 32'd0);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

`ifdef TRUTH_SWEEP_EN
      // Truth-table sweep of NAND with SWEEP_W=1
      sweep_mode = 1'b1;
      out_ready = 1'b1;
      in_op = 3'd2;
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      in_op = 3'd0;
      chk("sweep_busy", {31'd0, sweep_busy}, 32'd1);
      chk("sweep_in_ready", {31'd0, in_ready}, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) sw_y.push_back(out_y);
         if (sweep_done) done_cnt++;
      end
      chk("sweep_beats", sw_y.size(), 32'd4);
      for (int k = 0; k < 4 && k < sw_y.size(); k++) begin
         logic [W+1:0] e;
         logic [W-1:0] y;
         e = model(3'd2, W'(k >> 1), W'(k & 1));
         y = sw_y[k];
         chk("sweep_y", {24'd0, y}, {24'd0, e[W-1:0]});
         chk("sweep_y0", {31'd0, y[0]}, {31'd0, (k != 3)});
      end
      chk("sweep_done_once", done_cnt, 32'd1);
      chk("sweep_idle", {31'd0, sweep_busy}, 32'd0);
      sweep_mode = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
